// File: rtl/branch_predictor.sv
// Branch prediction and resolution unit.
// The fetch side does a combinational BHT/BTB lookup per PC. The execute side
// compares each resolved instruction with the prediction carried down the
// pipe, trains the tables, and issues a registered one-cycle mispredict pulse
// with the corrected fetch PC. After a pulse, resolutions are ignored for a
// fixed number of cycles while the wrong-path instructions drain.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | resolutions accepted; tables train; mispredict pulses
// ST_SQUASH | wrong-path drain; ex_valid ignored, squash_cnt counts down
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int PC_W       = 16,
  parameter int PC_INC     = 4,
  parameter int SQUASH_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            incorrect_pred,
  output logic [PC_W-1:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  // Prediction tables
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];

  logic [0:0] state;
  logic [3:0] squash_cnt;

  // Fetch-side lookup
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  // Execute-side resolution
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             resolve;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_next;
  logic [1:0]       ctr_next;

  // Combinational lookup; reads the pre-update table contents (no bypass)
  always_comb begin
    fetch_idx   = fetch_pc[IDX_W-1:0];
    fetch_tag   = fetch_pc[PC_W-1:IDX_W];
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    pred_target = fetch_hit ? target_q[fetch_idx] : '0;
  end

  // Resolution decode: hit check, mispredict detection, redirect and counter next values
  always_comb begin
    ex_idx  = ex_pc[IDX_W-1:0];
    ex_tag  = ex_pc[PC_W-1:IDX_W];
    ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    resolve = ex_valid && (state == ST_RUN);

    if (ex_is_branch) begin
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_target != ex_pred_target));
    end else begin
      // A non-branch can only look taken through an aliased table entry
      mispredict = ex_pred_taken;
    end

    if (ex_is_branch && ex_taken) begin
      redirect_next = ex_target;
    end else begin
      redirect_next = ex_pc + PC_W'(PC_INC);
    end

    ctr_next = ctr_q[ex_idx];
    if (ex_taken) begin
      if (ctr_q[ex_idx] != 2'b11) ctr_next = ctr_q[ex_idx] + 2'b01;
    end else begin
      if (ctr_q[ex_idx] != 2'b00) ctr_next = ctr_q[ex_idx] - 2'b01;
    end
  end

  // Table training on accepted resolutions, alongside the mispredict register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
        target_q[i] <= '0;
      end
    end else if (resolve) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ctr_next;
          if (ex_taken) target_q[ex_idx] <= ex_target;
        end else begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          ctr_q[ex_idx]    <= ex_taken ? CTR_WEAK_T : CTR_WEAK_NT;
          target_q[ex_idx] <= ex_target;
        end
      end else if (mispredict && ex_hit) begin
        // Drop the aliased entry so the same non-branch stops predicting taken
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // RUN/SQUASH sequencing with registered mispredict pulse and redirect PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      squash_cnt     <= '0;
      incorrect_pred <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          incorrect_pred <= 1'b0;
          if (resolve && mispredict) begin
            incorrect_pred <= 1'b1;
            redirect_pc    <= redirect_next;
            squash_cnt     <= 4'(SQUASH_CYC);
            state          <= ST_SQUASH;
          end
        end
        ST_SQUASH: begin
          incorrect_pred <= 1'b0;
          squash_cnt     <= squash_cnt - 4'd1;
          if (squash_cnt == 4'd1) state <= ST_RUN;
        end
        default: begin
          incorrect_pred <= 1'b0;
          state          <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter saturation,
// non-branch alias invalidation, squash window, PC wrap and mid-pulse reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [15:0] ex_pc;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        incorrect_pred;
  logic [15:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES(16), .PC_W(16), .PC_INC(4), .SQUASH_CYC(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_pc(fetch_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc),
    .ex_taken(ex_taken),
    .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .incorrect_pred(incorrect_pred),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_res(input logic v, input logic br, input logic [15:0] pc,
                         input logic tk, input logic [15:0] tgt,
                         input logic ptk, input logic [15:0] ptgt);
    ex_valid       = v;
    ex_is_branch   = br;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_res(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    fetch_pc = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL reset_pred_target: got %h expected 0000", pred_target); end
    checks++; if (incorrect_pred !== 1'b0) begin errors++; $display("FAIL reset_incorrect_pred: got %b expected 0", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0000) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0000", redirect_pc); end
    idle(1);
  endtask

  task automatic test_alloc;
    set_res(1, 1, 16'h0040, 1, 16'h0100, 0, 16'h0000);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL alloc_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0100) begin errors++; $display("FAIL alloc_redirect: got %h expected 0100", redirect_pc); end
    fetch_pc = 16'h0040; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 16'h0100) begin errors++; $display("FAIL alloc_pred_target: got %h expected 0100", pred_target); end
    @(posedge clk); #1;
    checks++; if (incorrect_pred !== 1'b0) begin errors++; $display("FAIL alloc_pulse_drop: got %b expected 0", incorrect_pred); end
    idle(3);
  endtask

  task automatic test_saturate;
    fetch_pc = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      set_res(1, 1, 16'h0040, 1, 16'h0100, 1, 16'h0100);
      @(posedge clk); #1;
      checks++; if (incorrect_pred !== 1'b0) begin errors++; $display("FAIL sat_taken_nopulse[%0d]: got %b expected 0", i, incorrect_pred); end
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_taken_pred[%0d]: got %b expected 1", i, pred_taken); end
    end
    // ctr 11 -> 10: still predicts taken only if it saturated at 11
    set_res(1, 1, 16'h0040, 0, 16'h0000, 1, 16'h0100);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL sat_nt1_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0044) begin errors++; $display("FAIL sat_nt1_redirect: got %h expected 0044", redirect_pc); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_nt1_pred: got %b expected 1", pred_taken); end
    idle(4);
    // ctr 10 -> 01
    set_res(1, 1, 16'h0040, 0, 16'h0000, 1, 16'h0100);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL sat_nt2_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0044) begin errors++; $display("FAIL sat_nt2_redirect: got %h expected 0044", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_nt2_pred: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 16'h0100) begin errors++; $display("FAIL sat_nt2_target_kept: got %h expected 0100", pred_target); end
    idle(4);
  endtask

  task automatic test_nonbranch;
    // 0x0050 aliases index 0 with 0x0040 and replaces it
    set_res(1, 1, 16'h0050, 1, 16'h0200, 0, 16'h0000);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (redirect_pc !== 16'h0200) begin errors++; $display("FAIL nb_alloc_redirect: got %h expected 0200", redirect_pc); end
    fetch_pc = 16'h0050; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL nb_alloc_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 16'h0200) begin errors++; $display("FAIL nb_alloc_target: got %h expected 0200", pred_target); end
    fetch_pc = 16'h0040; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nb_old_tag_miss: got %b expected 0", pred_taken); end
    idle(4);
    set_res(1, 0, 16'h0050, 0, 16'h0000, 1, 16'h0200);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL nb_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0054) begin errors++; $display("FAIL nb_redirect: got %h expected 0054", redirect_pc); end
    fetch_pc = 16'h0050; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nb_invalidated: got %b expected 0", pred_taken); end
    checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL nb_invalid_target: got %h expected 0000", pred_target); end
    idle(4);
  endtask

  task automatic test_squash;
    set_res(1, 1, 16'h0048, 1, 16'h0300, 0, 16'h0000);
    @(posedge clk); #1;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL sq_first_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0300) begin errors++; $display("FAIL sq_first_redirect: got %h expected 0300", redirect_pc); end
    // 0x0028 shares index 8; if accepted it would pulse and reallocate the entry
    set_res(1, 1, 16'h0028, 1, 16'h0400, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (incorrect_pred !== 1'b0) begin errors++; $display("FAIL sq_ignored_pulse[%0d]: got %b expected 0", i, incorrect_pred); end
    end
    fetch_pc = 16'h0048; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sq_table_kept_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 16'h0300) begin errors++; $display("FAIL sq_table_kept_target: got %h expected 0300", pred_target); end
    fetch_pc = 16'h0028; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sq_no_alloc: got %b expected 0", pred_taken); end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL sq_fourth_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0400) begin errors++; $display("FAIL sq_fourth_redirect: got %h expected 0400", redirect_pc); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sq_fourth_alloc_pred: got %b expected 1", pred_taken); end
    checks++; if (pred_target !== 16'h0400) begin errors++; $display("FAIL sq_fourth_alloc_target: got %h expected 0400", pred_target); end
    idle(4);
  endtask

  task automatic test_wrap;
    set_res(1, 1, 16'hFFFC, 0, 16'h1234, 1, 16'h1234);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0000) begin errors++; $display("FAIL wrap_redirect: got %h expected 0000", redirect_pc); end
  endtask

  task automatic test_reset_mid;
    // Entered mid-pulse from test_wrap, FSM in SQUASH
    fetch_pc = 16'hFFFC;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (incorrect_pred !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got %b expected 0", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0000) begin errors++; $display("FAIL rst_mid_redirect: got %h expected 0000", redirect_pc); end
    checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL rst_mid_table_cleared: got %h expected 0000", pred_target); end
    @(posedge clk); #1;
    rst = 1'b0;
    set_res(1, 1, 16'h0040, 1, 16'h0100, 0, 16'h0000);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (incorrect_pred !== 1'b1) begin errors++; $display("FAIL rst_fsm_run_pulse: got %b expected 1", incorrect_pred); end
    checks++; if (redirect_pc !== 16'h0100) begin errors++; $display("FAIL rst_fsm_run_redirect: got %h expected 0100", redirect_pc); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturate();
    test_nonbranch();
    test_squash();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
